// File: rtl/pam4_symbol_serializer_if.sv
// pam4_symbol_serializer_if: word handshake and symbol stream bundle.
// The DUT takes the slave side, the source/sink takes master.
interface pam4_symbol_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic                  sym_en;
  logic [1:0]            symbol_out;
  logic                  symbol_out_valid;
  logic                  word_start;
  logic                  underrun;

  modport master (
    output data_in,
    output data_in_valid,
    output sym_en,
    input  data_in_ready,
    input  symbol_out,
    input  symbol_out_valid,
    input  word_start,
    input  underrun
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    input  sym_en,
    output data_in_ready,
    output symbol_out,
    output symbol_out_valid,
    output word_start,
    output underrun
  );
endinterface

// File: rtl/pam4_symbol_serializer.sv
// pam4_symbol_serializer: slices words into 2-bit symbols, MSB first,
// one per sym_en strobe, with optional Gray mapping.
module pam4_symbol_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit GRAY_EN    = 1'b1
) (
  input logic clk,
  input logic rstn,
  pam4_symbol_serializer_if.slave io
);
  localparam int N  = DATA_WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  pend_v_q, pend_v_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            sym_q, sym_d;
  logic                  vld_q, vld_d;
  logic                  ws_q, ws_d;
  logic                  und_q, und_d;
  logic                  take;
  logic                  ready;
  logic                  accept;

  function automatic logic [1:0] map_sym(input logic [1:0] s);
    if (GRAY_EN) return {s[1], s[1] ^ s[0]};
    else return s;
  endfunction

  // The pending slot frees up in the same cycle it hands off to SHIFT.
  assign take   = io.sym_en & (cnt_q == '0) & pend_v_q;
  assign ready  = rstn & (!pend_v_q | take);
  assign accept = io.data_in_valid & ready;

  assign io.data_in_ready    = ready;
  assign io.symbol_out       = sym_q;
  assign io.symbol_out_valid = vld_q;
  assign io.word_start       = ws_q;
  assign io.underrun         = und_q;

  // Next state: drain SHIFT first, then PEND, else flag starvation.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    vld_d    = 1'b0;
    ws_d     = 1'b0;
    und_d    = 1'b0;
    if (io.sym_en) begin
      if (cnt_q != '0) begin
        sym_d   = map_sym(shift_q[DATA_WIDTH-1 -: 2]);
        shift_d = shift_q << 2;
        cnt_d   = cnt_q - CW'(1);
        vld_d   = 1'b1;
      end else if (pend_v_q) begin
        sym_d    = map_sym(pend_q[DATA_WIDTH-1 -: 2]);
        shift_d  = pend_q << 2;
        cnt_d    = CW'(N - 1);
        vld_d    = 1'b1;
        ws_d     = 1'b1;
        pend_v_d = 1'b0;
      end else begin
        und_d = 1'b1;
      end
    end
    if (accept) begin
      pend_d   = io.data_in;
      pend_v_d = 1'b1;
    end
  end

  // State and registered outputs; reset discards any word in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
      sym_q    <= 2'b00;
      vld_q    <= 1'b0;
      ws_q     <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      vld_q    <= vld_d;
      ws_q     <= ws_d;
      und_q    <= und_d;
    end
  end
endmodule
